// File: rtl/tiny_glut_result_collector.sv
// Result collector: buffers the unthrottled beat stream in a FWFT FIFO and re-emits it with m_tlast/stage_done.
// Optional macro TINY_GLUT_NAN_FLUSH_EN canonicalises bf16 NaN lanes at the FIFO write.
module tiny_glut_result_collector #(
  parameter int DATA_NUM   = 192,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stage_start,
  input  logic             in_tvalid,
  input  logic [63:0]      in_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [63:0]      m_tdata,
  output logic             m_tlast,
  output logic             stage_done,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      ONE_C   = (AW+1)'(1);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DATA_NUM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             stage_start_q;
  logic             start_pulse;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, beat_cnt_q, beat_cnt_d;
  logic             overflow_q, overflow_d;
  logic             stage_done_q, stage_done_d;
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [63:0]      wr_data;
  logic             wr_req, wr_en, rd_en, full;

  assign start_pulse = stage_start & ~stage_start_q;
  assign full        = (occ_q == DEPTH_C);
  assign m_tvalid    = (occ_q != '0);
  assign rd_en       = m_tvalid & m_tready;
  assign wr_req      = (state_q == COLLECT) & in_tvalid & ~start_pulse;
  // A full FIFO still accepts a write when a read frees the slot in the same cycle.
  assign wr_en       = wr_req & (~full | rd_en);
  assign m_tdata     = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tlast     = (state_q == DRAIN) & (occ_q == ONE_C);
  assign stage_done  = stage_done_q;
  assign overflow    = overflow_q;
  assign beat_cnt    = beat_cnt_q;

`ifdef TINY_GLUT_NAN_FLUSH_EN
  function automatic logic [63:0] nan_flush(input logic [63:0] d);
    logic [63:0] r;
    r = d;
    for (int unsigned i = 0; i < 4; i++) begin
      if (d[16*i+7 +: 8] == 8'hFF && d[16*i +: 7] != '0) begin
        r[16*i +: 16] = 16'h7FC0;
      end
    end
    return r;
  endfunction

  assign wr_data = nan_flush(in_tdata);
`else
  assign wr_data = in_tdata;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    in_cnt_d     = in_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    overflow_d   = overflow_q;
    stage_done_d = 1'b0;

    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase

    // Dropped beats still count, so a stage is always DATA_NUM input beats long.
    if (wr_req) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
      if (!wr_en) begin
        overflow_d = 1'b1;
      end
      if (in_cnt_q == LAST_C) begin
        state_d = DRAIN;
      end
    end

    if (state_q == DRAIN && rd_en && occ_q == ONE_C) begin
      state_d      = IDLE;
      stage_done_d = 1'b1;
    end

    if (start_pulse) begin
      state_d      = COLLECT;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      in_cnt_d     = '0;
      beat_cnt_d   = '0;
      overflow_d   = 1'b0;
      stage_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stage_start_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      in_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      stage_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_start_q <= stage_start;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      in_cnt_q      <= in_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      overflow_q    <= overflow_d;
      stage_done_q  <= stage_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_tiny_glut_result_collector.sv
// Directed bench for tiny_glut_result_collector: vector table for lane handling plus stage-level sequences.
module tb_tiny_glut_result_collector;

  logic        clk = 1'b0;
  logic        rst_n, stage_start, in_tvalid, m_tready;
  logic [63:0] in_tdata;
  logic        m_tvalid, m_tlast, stage_done, overflow;
  logic [63:0] m_tdata;
  logic [9:0]  beat_cnt;

  tiny_glut_result_collector #(.DATA_NUM(192), .FIFO_DEPTH(16), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start), .in_tvalid(in_tvalid),
    .in_tdata(in_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .stage_done(stage_done), .overflow(overflow), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

`ifdef TINY_GLUT_NAN_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    logic [63:0] din;
    logic [63:0] dexp;
  } vec_t;
  vec_t vt[5];

  int checks = 0, failures = 0;
  logic [63:0] sb[$];
  int mstate, in_n, m_bc, out_n, tlast_n, done_n;
  bit m_ovf;
  logic [63:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the reference model.
  task automatic tick(input bit st, input bit v, input logic [63:0] d, input logic [63:0] stored, input bit rdy);
    bit exp_valid, exp_last, hs, exp_done;
    logic [63:0] hd;
    logic hl;
    stage_start = st; in_tvalid = v; in_tdata = d; m_tready = rdy;
    exp_valid = (sb.size() != 0);
    exp_last  = (mstate == 2) && (sb.size() == 1);
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
    chk("m_tlast", 64'(m_tlast), 64'(exp_last));
    hs = exp_valid && rdy;
    hd = m_tdata;
    hl = m_tlast;
    @(posedge clk); #1;
    exp_done = 1'b0;
    if (st) begin
      sb.delete(); mstate = 1; in_n = 0; m_bc = 0; m_ovf = 1'b0;
    end else begin
      if (hs) begin
        out_n++; m_bc++;
        chk("out_data", hd, sb.pop_front());
        if (hl) begin tlast_n++; last_data = hd; end
        if (exp_last) begin exp_done = 1'b1; mstate = 0; end
      end
      if (mstate == 1 && v) begin
        if (sb.size() < 16) sb.push_back(stored); else m_ovf = 1'b1;
        in_n++;
        if (in_n == 192) mstate = 2;
      end
    end
    chk("stage_done", 64'(stage_done), 64'(exp_done));
    chk("beat_cnt", 64'(beat_cnt), 64'(m_bc));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (stage_done) done_n++;
  endtask

  task automatic beats(input int first, input int n, input bit rdy);
    for (int i = first; i < first + n; i++) tick(1'b0, 1'b1, 64'(i), 64'(i), rdy);
  endtask

  task automatic start_stage();
    tick(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1);
      if (stage_done) break;
    end
  endtask

  task automatic clear_stats();
    out_n = 0; tlast_n = 0; done_n = 0; last_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stage_start = 1'b0; in_tvalid = 1'b0; in_tdata = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete(); mstate = 0; in_n = 0; m_bc = 0; m_ovf = 1'b0;
  endtask

  initial begin
    vt[0] = '{64'h7F81_FF80_7F80_3F80, 64'h7FC0_FF80_7F80_3F80};
    vt[1] = '{64'hFFFF_7FC0_0000_8000, 64'h7FC0_7FC0_0000_8000};
    vt[2] = '{64'h7F80_0001_FF81_4049, 64'h7F80_0001_7FC0_4049};
    vt[3] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vt[4] = '{64'hFFC0_7FFF_7F7F_FF80, 64'h7FC0_7FC0_7F7F_FF80};
    if (!FLUSH) for (int i = 0; i < 5; i++) vt[i].dexp = vt[i].din;

    do_reset();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_stage_done", 64'(stage_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 64'hAA, 64'hAA, 1'b1);

    // Basic stream
    clear_stats(); start_stage(); beats(0, 192, 1'b1); drain();
    chk("basic_out_n", 64'(out_n), 64'd192);
    chk("basic_tlast_n", 64'(tlast_n), 64'd1);
    chk("basic_last_data", last_data, 64'd191);
    chk("basic_done_n", 64'(done_n), 64'd1);
    chk("basic_beat_cnt", 64'(beat_cnt), 64'd192);
    chk("basic_overflow", 64'(overflow), 64'd0);

    // Backpressure for the first 20 beats
    clear_stats(); start_stage();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 64'(i), 64'(i), 1'b0);
      if (i == 15) chk("bp_ovf_before", 64'(overflow), 64'd0);
      if (i == 16) chk("bp_ovf_after", 64'(overflow), 64'd1);
    end
    beats(20, 172, 1'b1); drain();
    chk("bp_out_n", 64'(out_n), 64'd188);
    chk("bp_last_data", last_data, 64'd191);
    chk("bp_done_n", 64'(done_n), 64'd1);
    chk("bp_beat_cnt", 64'(beat_cnt), 64'd188);
    chk("bp_overflow", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous read
    clear_stats(); start_stage(); beats(0, 16, 1'b0);
    chk("full_ovf_fill", 64'(overflow), 64'd0);
    for (int i = 16; i < 36; i++) begin
      tick(1'b0, 1'b1, 64'(i), 64'(i), ((i - 16) % 2) == 0);
      if (i == 16) chk("full_rd_no_drop", 64'(overflow), 64'd0);
    end
    beats(36, 156, 1'b1); drain();
    chk("full_out_n", 64'(out_n), 64'd182);
    chk("full_beat_cnt", 64'(beat_cnt), 64'd182);
    chk("full_done_n", 64'(done_n), 64'd1);

    // Restart mid-stage
    clear_stats(); start_stage(); beats(0, 30, 1'b1); beats(30, 20, 1'b0);
    chk("rs_beat_cnt_pre", 64'(beat_cnt), 64'd29);
    chk("rs_ovf_pre", 64'(overflow), 64'd1);
    tick(1'b1, 1'b1, 64'hDEAD, 64'hDEAD, 1'b0);
    chk("rs_flushed", 64'(m_tvalid), 64'd0);
    chk("rs_beat_cnt_clr", 64'(beat_cnt), 64'd0);
    chk("rs_ovf_clr", 64'(overflow), 64'd0);
    clear_stats(); beats(0, 192, 1'b1); drain();
    chk("rs_out_n", 64'(out_n), 64'd192);
    chk("rs_beat_cnt", 64'(beat_cnt), 64'd192);
    chk("rs_done_n", 64'(done_n), 64'd1);

    // Lane NaN handling vectors
    clear_stats(); start_stage();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, vt[i].din, vt[i].dexp, 1'b1);
      chk("nan_vec", m_tdata, vt[i].dexp);
    end
    beats(5, 187, 1'b1); drain();
    chk("nan_done_n", 64'(done_n), 64'd1);
    chk("nan_beat_cnt", 64'(beat_cnt), 64'd192);

    // Async reset mid-DRAIN
    clear_stats(); start_stage(); beats(0, 192, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_m_tlast", 64'(m_tlast), 64'd0);
    chk("arst_stage_done", 64'(stage_done), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_m_tdata", m_tdata, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete(); mstate = 0; in_n = 0; m_bc = 0; m_ovf = 1'b0; done_n = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 64'h55, 64'h55, 1'b1);
    chk("arst_no_done", 64'(done_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tiny_glut_result_collector.md
# tiny_glut_result_collector

Downstream stage of the tiny snake-array top. Consumes the unthrottled `result_tvalid`/`result_tdata` beat stream, which carries four bf16 lanes per 64-bit beat. Buffers the beats in a small FIFO and re-emits them as a backpressured stream with `m_tlast` on the final beat of a stage. Counts exactly DATA_NUM input beats per stage, then pulses `stage_done` and flags any beats dropped because the FIFO was full.

## Interface
Parameters:
- DATA_NUM, 192: input beats per stage; must be ≥1.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2.
- CNT_W, 10: beat counter width; must satisfy 2^CNT_W > DATA_NUM.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stage_start  in  1  level; a rising edge starts or restarts a stage.
- in_tvalid  in  1  input beat valid; no backpressure upstream.
- in_tdata  in  64  four bf16 lanes; lane0 = [15:0].
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  64  output beat.
- m_tlast  out  1  marks the final beat of the stage.
- stage_done  out  1  one-cycle pulse when the last beat is accepted.
- overflow  out  1  sticky; at least one beat was dropped this stage.
- beat_cnt  out  CNT_W  output beats accepted this stage.

## Operation
- Start detect: `start_pulse = stage_start & ~stage_start_q`, where `stage_start_q` is stage_start registered once.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE: ignores in_tvalid; start_pulse → COLLECT.
  - COLLECT: each in_tvalid beat is an input beat and increments in_cnt.
    - On the edge where in_cnt reaches DATA_NUM → DRAIN.
  - DRAIN: in_tvalid is ignored. When the m_tlast beat is accepted → IDLE, and stage_done = 1 for that one cycle.
- start_pulse in any state, including mid-stage: synchronously flushes the FIFO and clears in_cnt, beat_cnt and overflow, then → COLLECT. That same cycle's in_tvalid is ignored.
- FIFO is first-word-fall-through. Pointers are log2(FIFO_DEPTH) bits and wrap; occupancy is tracked as a (log2+1)-bit count.
  - m_tvalid = (occupancy != 0); m_tdata = mem[rd_ptr].
  - Read occurs when m_tvalid & m_tready.
- Write accepted when occupancy < FIFO_DEPTH, or when a read occurs in the same cycle (full with simultaneous read: both happen, occupancy unchanged).
- Write while full without a read: the beat is dropped, overflow set to 1, and in_cnt still increments. Stage length is therefore always DATA_NUM input beats.
- m_tlast = (state == DRAIN) & (occupancy == 1). DRAIN is never entered with an empty FIFO.
- beat_cnt increments on each accepted output beat and holds its value in IDLE until the next start_pulse.
- Reset values:
  - Outputs: m_tvalid, m_tlast, stage_done, overflow = 0; beat_cnt = 0; m_tdata = 0.
  - Internal: memory contents are don't-care; state = IDLE.

## Timing
- Latency: with the FIFO empty, an in_tvalid beat sampled at edge N gives m_tvalid = 1 right after edge N (1 cycle).
- A start_pulse at edge N means beats are accepted from edge N+1. stage_start itself is registered internally, so start_pulse is combinational from the pin and must be held ≥1 cycle.
- stage_done asserts right after the edge that accepts the tlast beat and deasserts one cycle later.
- With m_tready held at 1, throughput is 1 beat per cycle and overflow can never occur.
- Asynchronous reset mid-stage aborts immediately: all state clears and no stage_done is produced.

## Configuration
- TINY_GLUT_NAN_FLUSH_EN defined: at the FIFO write, every bf16 lane with exp = 8'hFF and mantissa ≠ 0 is replaced by 16'h7FC0 (canonical quiet NaN). ±Inf and all other values pass unchanged.
- Not defined: data is stored and emitted bit-exact.

## Test plan
- Basic stream: reset, start_pulse, 192 consecutive beats with data = index, m_tready = 1.
  - Expect 192 output beats in order, each 1 cycle after its input.
  - Expect m_tlast only on beat 191, stage_done one cycle later, beat_cnt = 192, overflow = 0.
- Backpressure: m_tready = 0 for the first 20 input beats.
  - Expect the first 16 beats kept and beats 16–19 dropped, overflow = 1.
  - Expect 188 output beats, m_tlast on the beat carrying index 191, stage_done asserted.
- Full with simultaneous read: FIFO full, m_tready toggling 1/0 while in_tvalid = 1 every cycle.
  - On cycles with m_tready = 1, expect the write accepted and no drop.
- Restart: start_pulse after 50 beats.
  - Expect FIFO flushed and counters at 0; the new stage of 192 beats completes normally with beat_cnt = 192.
- Async reset: rst_n low for 1 cycle mid-DRAIN.
  - Expect all outputs 0 immediately, no stage_done, and in_tvalid ignored until the next start_pulse.
- NaN flush: beat 64'h7F81_FF80_7F80_3F80.
  - With the macro defined, expect 64'h7FC0_FF80_7F80_3F80.
  - Without it, expect the beat unchanged.
